fetch_stage: RTL

// - Instruction-fetch front end. Owns the PC, issues requests to instruction memory,
//   and drives the fetch->decode pipeline register (instruction, oldPC, newPC + valid).
// - Upstream producer for the F/D flops. Honours decode back-pressure, branch redirects

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 77 +++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode-side controls and F/D register outputs.
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;
  logic               fd_stall;
  logic               redirect_en;
  logic [PC_W-1:0]    redirect_pc;
  logic               fd_valid;
  logic [INSTR_W-1:0] fd_instr;
  logic [PC_W-1:0]    fd_oldPC;
  logic [PC_W-1:0]    fd_newPC;
  logic               halted;

  modport master (
    output imem_req, imem_addr, fd_valid, fd_instr, fd_oldPC, fd_newPC, halted,
    input  imem_valid, imem_data, fd_stall, redirect_en, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, fd_valid, fd_instr, fd_oldPC, fd_newPC, halted,
    output imem_valid, imem_data, fd_stall, redirect_en, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, handshakes with imem, drives the F/D register.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall counters.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]  perf_fetched,
  output logic [15:0]  perf_stall,
`endif
  fetch_stage_if.master bus
);

  typedef enum logic [0:0] {FETCH, HALTED} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            out_free;
  logic            transfer;
  logic            is_halt;

  assign out_free     = !bus.fd_valid || !bus.fd_stall;
  assign bus.imem_req = (state == FETCH) && !rst && out_free && !bus.redirect_en;
  assign bus.imem_addr = pc;
  assign transfer     = bus.imem_req && bus.imem_valid;
  assign is_halt      = (bus.imem_data[INSTR_W-1 -: 4] == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      bus.fd_valid <= 1'b0;
      bus.fd_instr <= '0;
      bus.fd_oldPC <= '0;
      bus.fd_newPC <= '0;
      bus.halted   <= 1'b0;
    end else if (bus.redirect_en) begin
      // Redirect flushes only valid; the stale payload is never observed.
      state        <= FETCH;
      pc           <= bus.redirect_pc;
      bus.fd_valid <= 1'b0;
      bus.halted   <= 1'b0;
    end else if (transfer) begin
      bus.fd_valid <= 1'b1;
      bus.fd_instr <= bus.imem_data;
      bus.fd_oldPC <= pc;
      if (is_halt) begin
        bus.fd_newPC <= pc;
        state        <= HALTED;
        bus.halted   <= 1'b1;
      end else begin
        bus.fd_newPC <= pc + PC_W'(2);
        pc           <= pc + PC_W'(2);
      end
    end else if (!bus.fd_stall) begin
      bus.fd_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (transfer && perf_fetched != '1)
        perf_fetched <= perf_fetched + 16'd1;
      if (bus.fd_valid && bus.fd_stall && perf_stall != '1)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
